addsub_pipe: RTL and testbench
==============================

ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages; legal range 1..4.
REQ-003 Parameter SAT, default 0; 0 selects wrap-around arithmetic, 1 selects unsigned saturation.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in1  input  WIDTH  operand A.
REQ-007 in2  input  WIDTH  operand B.
REQ-008 mode  input  1  0 = add (A+B), 1 = subtract (A-B).
REQ-009 in_valid  input  1  operand beat offered.
REQ-010 in_ready  output  1  block accepts the beat this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 cout  output  1  carry for add, borrow for subtract (unsigned).
REQ-013 ovf  output  1  signed two's-complement overflow of the unsaturated result.
REQ-014 out_valid  output  1  result beat offered.
REQ-015 out_ready  input  1  consumer accepts the result this cycle.
REQ-016 txn_count  output  16  number of completed output handshakes.

Function
REQ-017 An input beat is accepted on a rising edge where in_valid and in_ready are both 1; an output beat completes where out_valid and out_ready are both 1.
REQ-018 Add: out = (in1+in2) mod 2^WIDTH; cout = bit WIDTH of the (WIDTH+1)-bit sum.
REQ-019 Subtract: out = (in1-in2) mod 2^WIDTH; cout = 1 if in1 < in2 (unsigned).
REQ-020 ovf = 1 when: add, both operand MSBs equal and result MSB differs; subtract, operand MSBs differ and result MSB differs from in1 MSB.
REQ-021 SAT=1: add with cout=1 drives out to all ones; subtract with cout=1 drives out to zero; cout and ovf are still reported.
REQ-022 The result is computed at acceptance and carried through STAGES registered stages, each holding a valid bit plus {out, cout, ovf}.
REQ-023 Without backpressure, out_valid asserts exactly STAGES cycles after the accepting edge.
REQ-024 A stage loads when its downstream stage is empty or is itself advancing in the same cycle; sustained throughput is one beat per cycle.
REQ-025 in_ready = first stage empty OR first stage advancing; in_ready is independent of in_valid.
REQ-026 While out_valid=1 and out_ready=0, out, cout and ovf hold stable and no beat is lost or duplicated.
REQ-027 When all STAGES stages are full and out_ready=0, in_ready=0.
REQ-028 When an input accept and an output handshake occur in the same cycle with the pipe full, both complete and occupancy is unchanged.
REQ-029 Beats leave in acceptance order.
REQ-030 txn_count increments by 1 per output handshake and wraps from 0xFFFF to 0x0000.
REQ-031 When out_valid=0, out, cout and ovf hold their last values and are don't-care to the consumer.

Reset
REQ-032 rst=0 asynchronously clears all stage valid bits, out, cout, ovf and txn_count to 0, independent of clk.
REQ-033 While rst=0, in_ready=0 and out_valid=0.
REQ-034 A reset asserted mid-operation discards all in-flight beats; no result from before reset appears after release.
REQ-035 After rst deassertion, in_ready=1 on the first rising edge.

Structure
REQ-036 Package addsub_pkg holds the mode constants MODE_ADD=0 and MODE_SUB=1 and a parametrisable result struct {out, cout, ovf}.
REQ-037 Sub-module addsub_stage implements one valid/ready register stage; addsub_pipe instantiates it STAGES times through a generate loop.
REQ-038 The arithmetic and saturation logic sits combinationally ahead of stage 0 in addsub_pipe.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-039 Add 200+100, SAT=0, out_ready=1 -> two cycles later out=44, cout=1, ovf=0; same beat with SAT=1 -> out=255, cout=1.
REQ-040 Subtract 5-10 -> out=251, cout=1, ovf=0; SAT=1 -> out=0; subtract 0x80-0x01 -> out=0x7F, ovf=1.
REQ-041 Add 0x7F+0x01 -> out=0x80, cout=0, ovf=1.
REQ-042 Ten back-to-back beats with out_ready held 0 -> in_ready drops after the second accept, out is stable; release out_ready -> all ten results in order, txn_count=10.
REQ-043 Assert rst=0 with two beats in flight -> out_valid=0 and txn_count=0 immediately; after release no stale result emerges.
REQ-044 Preload txn_count to 0xFFFF through 65535 handshakes, then one more handshake -> txn_count=0x0000.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared mode encodings and result record for the add/subtract pipeline.
// The record is sized for the widest legal instance; narrower instances use the low bits of out.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int RES_MAX_W = 32;

  typedef struct packed {
    logic [RES_MAX_W-1:0] out;
    logic                 cout;
    logic                 ovf;
  } addsub_res_t;

endpackage

// File: rtl/addsub_stage.sv
// One valid/ready register stage: holds a single beat and passes it on when downstream takes it.
// The ready path is combinational so a chain of stages sustains one beat per cycle.
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data
);

  logic          vld_q;
  logic          vld_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  // Load when empty, or when the held beat leaves in this same cycle.
  assign in_rdy = !vld_q || out_rdy;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (in_rdy) begin
      vld_d = in_vld;
      if (in_vld) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_data = data_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with carry/borrow, signed overflow and optional unsigned saturation.
// The result is formed combinationally at acceptance, then travels through STAGES valid/ready stages.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      txn_count
);

  localparam int DW = WIDTH + 2;

  // Raw result: wrapped value, carry/borrow from bit WIDTH, signed overflow.
  function automatic addsub_res_t calc_raw(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             m);
    addsub_res_t r;
    logic [WIDTH:0] wide;
    r = '0;
    if (m == MODE_SUB) begin
      wide  = {1'b0, a} - {1'b0, b};
      r.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
    end else begin
      wide  = {1'b0, a} + {1'b0, b};
      r.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
    end
    r.out[WIDTH-1:0] = wide[WIDTH-1:0];
    r.cout           = wide[WIDTH];
    return r;
  endfunction

  // Unsigned clamp; flags still describe the unsaturated operation.
  function automatic addsub_res_t saturate(input addsub_res_t r, input logic m);
    addsub_res_t s;
    s = r;
    if ((SAT != 0) && r.cout) begin
      s.out[WIDTH-1:0] = (m == MODE_SUB) ? '0 : '1;
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] form_beat(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             m);
    addsub_res_t s;
    s = saturate(calc_raw(a, b, m), m);
    return {s.out[WIDTH-1:0], s.cout, s.ovf};
  endfunction

  logic [DW-1:0] beat_p0;

  always_comb begin
    beat_p0 = form_beat(in1, in2, mode);
  end

  // Stage chain: stage 0 takes the freshly computed beat, the last stage drives the outputs.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          up_vld;
    logic          up_rdy;
    logic [DW-1:0] up_data;
    logic          dn_vld;
    logic          dn_rdy;
    logic [DW-1:0] dn_data;

    if (i == 0) begin : g_head
      assign up_vld  = in_valid;
      assign up_data = beat_p0;
    end else begin : g_link
      assign up_vld  = g_stage[i-1].dn_vld;
      assign up_data = g_stage[i-1].dn_data;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_fwd
      assign dn_rdy = g_stage[i+1].up_rdy;
    end

    addsub_stage #(
      .DW(DW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (up_vld),
      .in_rdy  (up_rdy),
      .in_data (up_data),
      .out_vld (dn_vld),
      .out_rdy (dn_rdy),
      .out_data(dn_data)
    );
  end

  // Stages are held empty during reset, but ready must also read low then.
  assign in_ready  = rst & g_stage[0].up_rdy;
  assign out_valid = g_stage[STAGES-1].dn_vld;
  assign out       = g_stage[STAGES-1].dn_data[DW-1:2];
  assign cout      = g_stage[STAGES-1].dn_data[1];
  assign ovf       = g_stage[STAGES-1].dn_data[0];

  logic [15:0] txn_q;
  logic [15:0] txn_d;

  always_comb begin
    txn_d = txn_q;
    if (out_valid && out_ready) begin
      txn_d = txn_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn_q <= '0;
    end else begin
      txn_q <= txn_d;
    end
  end

  assign txn_count = txn_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: a wrapping and a saturating instance share stimulus; a scoreboard
// holds model results pushed at acceptance and a monitor pops them at each output handshake.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic        rdy_w, rdy_s;
  logic [7:0]  out_w, out_s;
  logic        cout_w, cout_s, ovf_w, ovf_s, vld_w, vld_s;
  logic [15:0] txn_w, txn_s;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy_w), .out(out_w), .cout(cout_w), .ovf(ovf_w),
    .out_valid(vld_w), .out_ready(out_ready), .txn_count(txn_w)
  );

  addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .mode(mode),
    .in_valid(in_valid), .in_ready(rdy_s), .out(out_s), .cout(cout_s), .ovf(ovf_s),
    .out_valid(vld_s), .out_ready(out_ready), .txn_count(txn_s)
  );

  typedef struct packed {
    logic [7:0] o;
    logic       c;
    logic       v;
  } exp_t;

  exp_t        q_w[$];
  exp_t        q_s[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] tb_txn = '0;
  logic        hold_vld[2];
  exp_t        hold_val[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic with operands read as unsigned and as signed.
  function automatic exp_t model(input int a, input int b, input logic m, input logic sat);
    exp_t e;
    int r, sa, sb, sr;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    if (m) begin
      r   = a - b;
      sr  = sa - sb;
      e.c = (a < b);
    end else begin
      r   = a + b;
      sr  = sa + sb;
      e.c = (r > 255);
    end
    e.v = (sr > 127) || (sr < -128);
    e.o = 8'(r & 255);
    if (sat && e.c) e.o = m ? 8'd0 : 8'd255;
    return e;
  endfunction

  task automatic mon(input int k, input logic ov, input logic [7:0] o, input logic c, input logic v);
    exp_t cur, e;
    cur = {o, c, v};
    if (ov && out_ready) begin
      if ((k == 0 && q_w.size() == 0) || (k == 1 && q_s.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out dut%0d: got %0h expected no output", k, cur);
      end else begin
        e = (k == 0) ? q_w.pop_front() : q_s.pop_front();
        chk(k == 0 ? "result_wrap" : "result_sat", {22'd0, cur}, {22'd0, e});
      end
      hold_vld[k] = 1'b0;
      if (k == 0) tb_txn = tb_txn + 16'd1;
    end else if (ov) begin
      if (hold_vld[k]) chk(k == 0 ? "hold_wrap" : "hold_sat", {22'd0, cur}, {22'd0, hold_val[k]});
      hold_vld[k] = 1'b1;
      hold_val[k] = cur;
    end else begin
      hold_vld[k] = 1'b0;
    end
  endtask

  // Handshakes are sampled half a cycle before the edge that completes them.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      q_w.delete();
      q_s.delete();
      tb_txn      = '0;
      hold_vld[0] = 1'b0;
      hold_vld[1] = 1'b0;
    end else begin
      if (in_valid && rdy_w) begin
        q_w.push_back(model(int'(in1), int'(in2), mode, 1'b0));
        q_s.push_back(model(int'(in1), int'(in2), mode, 1'b1));
      end
      mon(0, vld_w, out_w, cout_w, ovf_w);
      mon(1, vld_s, out_s, cout_s, ovf_s);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic got;
    got = 1'b0;
    in1 = a; in2 = b; mode = m; in_valid = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = rdy_w;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 64 && q_w.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q_w.size(), 0);
  endtask

  task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input logic [7:0] eo, input logic ec, input logic ev,
                          input logic [7:0] es);
    int lat;
    out_ready = 1'b1;
    send(a, b, m);
    lat = 0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (vld_w) begin
        lat = t;
        break;
      end
    end
    chk("latency", lat, STAGES);
    chk("out_wrap", {24'd0, out_w}, {24'd0, eo});
    chk("cout_wrap", {31'd0, cout_w}, {31'd0, ec});
    chk("ovf_wrap", {31'd0, ovf_w}, {31'd0, ev});
    chk("out_sat", {24'd0, out_s}, {24'd0, es});
    chk("cout_sat", {31'd0, cout_s}, {31'd0, ec});
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ba[10];
  logic [7:0] bb[10];
  logic       bm[10];
  int         idx;
  int         stale;
  int         cnt;

  initial begin
    #3;
    chk("rst_in_ready", {31'd0, rdy_w}, 0);
    chk("rst_out_valid", {31'd0, vld_w}, 0);
    chk("rst_txn", {16'd0, txn_w}, 0);
    chk("rst_out", {24'd0, out_w}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, rdy_w}, 1);
    @(posedge clk);
    #1;

    directed(8'd200, 8'd100, MODE_ADD, 8'd44, 1'b1, 1'b0, 8'd255);
    directed(8'd5, 8'd10, MODE_SUB, 8'd251, 1'b1, 1'b0, 8'd0);
    directed(8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b0, 1'b1, 8'h7F);
    directed(8'h7F, 8'h01, MODE_ADD, 8'h80, 1'b0, 1'b1, 8'h80);

    // Reset with two beats in flight.
    send(8'd11, 8'd22, MODE_ADD);
    send(8'd33, 8'd44, MODE_SUB);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, vld_w}, 0);
    chk("midrst_txn", {16'd0, txn_w}, 0);
    chk("midrst_in_ready", {31'd0, rdy_w}, 0);
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (vld_w || vld_s) stale++;
    end
    chk("no_stale", stale, 0);
    @(posedge clk);
    #1;

    // Backpressure: ten beats offered while the consumer stalls.
    for (int i = 0; i < 10; i++) begin
      ba[i] = 8'($urandom);
      bb[i] = 8'($urandom);
      bm[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    idx = 0;
    in1 = ba[0]; in2 = bb[0]; mode = bm[0]; in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rdy_w) idx++;
      @(posedge clk);
      #1;
      if (idx < 10) begin
        in1 = ba[idx]; in2 = bb[idx]; mode = bm[idx];
      end
    end
    chk("bp_accepts", idx, STAGES);
    chk("bp_in_ready", {31'd0, rdy_w}, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      @(negedge clk);
      if (rdy_w) idx++;
      @(posedge clk);
      #1;
      if (idx < 10) begin
        in1 = ba[idx]; in2 = bb[idx]; mode = bm[idx];
      end
    end
    in_valid = 1'b0;
    chk("bp_all_sent", idx, 10);
    drain();
    chk("bp_txn", {16'd0, txn_w}, 10);

    // Random traffic with random stalls on both sides.
    for (int c = 0; c < 500; c++) begin
      in1       = 8'($urandom);
      in2       = 8'($urandom);
      mode      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_txn", {16'd0, txn_w}, {16'd0, tb_txn});

    // Counter wrap: 65535 handshakes, then one more.
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cnt = 0;
    for (int c = 0; c < 70000 && cnt < 65535; c++) begin
      in1  = 8'($urandom);
      in2  = 8'($urandom);
      mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rdy_w) cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("wrap_sent", cnt, 65535);
    drain();
    chk("txn_ffff", {16'd0, txn_w}, 32'h0000FFFF);
    send(8'($urandom), 8'($urandom), MODE_ADD);
    drain();
    chk("txn_wrap", {16'd0, txn_w}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
